// File: rtl/spi_scan_bridge_pkg.sv
// Shared definitions for the SPI scan bridge: FSM state codes, the bit
// counter width helper and the idle levels loaded into the pin synchronizers.
package spi_scan_bridge_pkg;

  // Frame FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_CHECK = 2'd2;

  // The counter must hold 0..CHAIN_LEN+1 so an overrun stays distinguishable
  // from an exact-length frame.
  function automatic int cnt_w(input int chain_len);
    return $clog2(chain_len + 2);
  endfunction

  // Levels the synchronizers present while reset is asserted
  localparam logic IDLE_SCK   = 1'b0;
  localparam logic IDLE_CS_N  = 1'b1;
  localparam logic IDLE_MOSI  = 1'b0;
  localparam logic IDLE_RUN_N = 1'b1;

endpackage

// File: rtl/spi_scan_bridge_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus a delay flop used to
// detect rising and falling edges of the synchronized level.
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;
  // Tracks how many flops hold genuinely sampled pin data since reset. Edges
  // are suppressed until the delay flop holds a real sample, so a pin already
  // away from its idle level at reset release is not mistaken for an edge.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   primed;

  // Synchronizer chain, delay flop and fill tracker
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      dly_q  <= RST_VAL;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign primed = fill_q[SYNC_STAGES];
  assign level  = sync_q[SYNC_STAGES-1];
  assign rise   = primed &  level & ~dly_q;
  assign fall   = primed & ~level &  dly_q;

endmodule

// File: rtl/spi_scan_bridge.sv
// SPI pin front-end for the accumulator core scan chain: oversamples the pins,
// turns SCK rises into single-cycle scan_enable strobes, returns scan_out on
// MISO, checks the frame length and keeps proc_en off while a frame is open.
import spi_scan_bridge_pkg::*;

module spi_scan_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int CHAIN_LEN   = 136
) (
  input  logic clk,
  input  logic rst_n,
  input  logic spi_sck,
  input  logic spi_cs_n,
  input  logic spi_mosi,
  input  logic run_n,
  input  logic scan_out,
  input  logic halt_in,
  output logic scan_enable,
  output logic scan_in,
  output logic proc_en,
  output logic spi_miso,
  output logic busy,
  output logic frame_ok,
  output logic frame_err
);

  localparam int             CW      = cnt_w(CHAIN_LEN);
  localparam logic [CW-1:0]  CNT_LEN = CW'(CHAIN_LEN);
  localparam logic [CW-1:0]  CNT_SAT = CW'(CHAIN_LEN + 1);

  logic sck_rise, sck_fall, sck_level_unused;
  logic cs_rise, cs_fall, cs_level_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic run_n_level, run_rise_unused, run_fall_unused;

  state_t         state, state_nxt;
  logic [CW-1:0]  bit_cnt;
  logic           miso_q;
  logic           frame_start;
  logic           shift_rise;
  logic           shift_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_SCK)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_sck),
    .level (sck_level_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_CS_N)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_cs_n),
    .level (cs_level_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_MOSI)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spi_mosi),
    .level (mosi_level),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(IDLE_RUN_N)) u_sync_run (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (run_n),
    .level (run_n_level),
    .rise  (run_rise_unused),
    .fall  (run_fall_unused)
  );

  // Qualified events: CS deassertion overrides any SCK edge in the same cycle
  assign frame_start = (state == ST_IDLE)  & cs_fall;
  assign shift_rise  = (state == ST_SHIFT) & ~cs_rise & sck_rise;
  assign shift_fall  = (state == ST_SHIFT) & ~cs_rise & sck_fall;

  // Next-state decode for the frame FSM
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cs_rise) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame bit counter, saturating one past the chain length to flag overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (frame_start) begin
      bit_cnt <= '0;
    end else if (shift_rise && (bit_cnt != CNT_SAT)) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // One-clock shift strobe with the synchronized MOSI bit beside it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_enable <= 1'b0;
      scan_in     <= 1'b0;
    end else begin
      scan_enable <= shift_rise;
      if (shift_rise) begin
        scan_in <= mosi_level;
      end
    end
  end

  // MISO holding register: first bit at CS fall, then refreshed on each SCK
  // fall once the core has shifted out its next bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_q <= 1'b0;
    end else if (frame_start || shift_fall) begin
      miso_q <= scan_out;
    end
  end

  // Sticky frame status, cleared when the next frame opens
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else if (frame_start) begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else if (state == ST_CHECK) begin
      if (bit_cnt == CNT_LEN) begin
        frame_ok  <= 1'b1;
      end else begin
        frame_err <= 1'b1;
      end
    end
  end

  // proc_en follows the registered state, so it is already low in any cycle
  // where a scan_enable strobe can be present
  assign busy     = (state != ST_IDLE);
  assign proc_en  = ~run_n_level & (state == ST_IDLE);
  assign spi_miso = (state == ST_SHIFT) ? miso_q : (proc_en & halt_in);

endmodule
